// File: rtl/pipe_run_if.sv
// Run-control bundle between the pipeline sequencer (slave) and the requester
// that issues start/step/halt and reports pipeline status (master).
interface pipe_run_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             step_req;
    logic             halt_req;
    logic             jump_taken;
    logic             wb_valid;
    logic             clear_counts;
    logic             pc_en;
    logic             ifid_flush;
    logic [7:0]       ifid_nop_code;
    logic             busy;
    logic             done;
    logic [1:0]       state;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] retired_count;

    modport master (
        output start, step_req, halt_req, jump_taken, wb_valid, clear_counts,
        input  pc_en, ifid_flush, ifid_nop_code, busy, done, state,
               cycle_count, retired_count
    );

    modport slave (
        input  start, step_req, halt_req, jump_taken, wb_valid, clear_counts,
        output pc_en, ifid_flush, ifid_nop_code, busy, done, state,
               cycle_count, retired_count
    );
endinterface

// File: rtl/pipe_run_controller.sv
// Run/halt/single-step sequencer for the IF -> ID -> EX/WB pipeline: gates
// fetch, injects NOP bubbles, drains in-flight work and keeps run counters.
//
//   state | meaning
//   IDLE  | stopped, IF/ID fed bubbles, PC frozen unless a jump resolves
//   RUN   | fetch every cycle until halt_req
//   STEP  | single fetch cycle, then drain
//   DRAIN | PIPE_DEPTH bubble cycles so the last fetched op retires
module pipe_run_controller #(
    parameter int         PIPE_DEPTH = 3,
    parameter int         CNT_W      = 16,
    parameter logic [7:0] NOP_CODE   = 8'h80
) (
    input  logic        clk,
    input  logic        reset,
    pipe_run_if.slave   bus
);
    localparam int DW = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
    localparam logic [DW-1:0]    DRAIN_LOAD = DW'(PIPE_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        STEP  = 2'b10,
        DRAIN = 2'b11
    } state_t;

    state_t           state_q;
    logic [DW-1:0]    drain_cnt;
    logic             done_q;
    logic [CNT_W-1:0] cycle_q;
    logic [CNT_W-1:0] retired_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            drain_cnt <= '0;
            done_q    <= 1'b0;
            cycle_q   <= '0;
            retired_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start)
                        state_q <= RUN;
                    else if (bus.step_req)
                        state_q <= STEP;
                end
                RUN: begin
                    if (bus.halt_req) begin
                        state_q   <= DRAIN;
                        drain_cnt <= DRAIN_LOAD;
                    end
                end
                STEP: begin
                    state_q   <= DRAIN;
                    drain_cnt <= DRAIN_LOAD;
                end
                DRAIN: begin
                    // requests arriving here are dropped, not queued
                    if (drain_cnt == '0) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - DW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (bus.clear_counts) begin
                cycle_q   <= '0;
                retired_q <= '0;
            end else begin
                if (state_q != IDLE && cycle_q != CNT_MAX)
                    cycle_q <= cycle_q + CNT_W'(1);
                if (bus.wb_valid && retired_q != CNT_MAX)
                    retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    // a jump resolving while stopped still moves the PC so the next run resumes there
    assign bus.pc_en         = (state_q == RUN) || (state_q == STEP) || bus.jump_taken;
    assign bus.ifid_flush    = (state_q == IDLE) || (state_q == DRAIN) || bus.jump_taken;
    assign bus.ifid_nop_code = NOP_CODE;
    assign bus.busy          = (state_q != IDLE);
    assign bus.done          = done_q;
    assign bus.state         = state_q;
    assign bus.cycle_count   = cycle_q;
    assign bus.retired_count = retired_q;
endmodule

// File: tb/tb_pipe_run_controller.sv
// Scoreboard bench: directed rows push hand-computed expectations, a negedge
// monitor pops and compares a 16-bit and a 4-bit (saturating) instance.
module tb_pipe_run_controller;
    localparam int R = 64, S = 32, P = 16, H = 8, J = 4, W = 2, C = 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipe_run_if #(.CNT_W(16)) bus16 ();
    pipe_run_if #(.CNT_W(4))  bus4 ();

    pipe_run_controller #(.PIPE_DEPTH(3), .CNT_W(16), .NOP_CODE(8'h80)) dut16 (
        .clk(clk), .reset(reset), .bus(bus16));
    pipe_run_controller #(.PIPE_DEPTH(3), .CNT_W(4), .NOP_CODE(8'h80)) dut4 (
        .clk(clk), .reset(reset), .bus(bus4));

    typedef struct {
        int id;
        int st, pe, fl, dn, cc, rc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   row_id = 0;

    task automatic chk(input string name, input int id, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s row %0d: got %0d expected %0d", name, id, act, req);
        end
    endtask

    task automatic drive(input int in);
        reset = in[6];
        bus16.start = in[5];     bus4.start = in[5];
        bus16.step_req = in[4];  bus4.step_req = in[4];
        bus16.halt_req = in[3];  bus4.halt_req = in[3];
        bus16.jump_taken = in[2]; bus4.jump_taken = in[2];
        bus16.wb_valid = in[1];  bus4.wb_valid = in[1];
        bus16.clear_counts = in[0]; bus4.clear_counts = in[0];
    endtask

    // inputs held for one cycle; expectation is what the outputs show in that cycle
    task automatic row(input int in, input int st, input int pe, input int fl,
                       input int dn, input int cc, input int rc);
        exp_t e;
        @(posedge clk); #1;
        drive(in);
        e.id = row_id; e.st = st; e.pe = pe; e.fl = fl; e.dn = dn; e.cc = cc; e.rc = rc;
        exp_q.push_back(e);
        row_id++;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("state",      e.id, int'(bus16.state),      e.st);
                chk("pc_en",      e.id, int'(bus16.pc_en),      e.pe);
                chk("ifid_flush", e.id, int'(bus16.ifid_flush), e.fl);
                chk("busy",       e.id, int'(bus16.busy),       (e.st != 0) ? 1 : 0);
                chk("done",       e.id, int'(bus16.done),       e.dn);
                chk("nop_code",   e.id, int'(bus16.ifid_nop_code), 8'h80);
                chk("cycle_count",   e.id, int'(bus16.cycle_count),   e.cc);
                chk("retired_count", e.id, int'(bus16.retired_count), e.rc);
                chk("state4",     e.id, int'(bus4.state),       e.st);
                chk("cycle_count4",   e.id, int'(bus4.cycle_count),   (e.cc > 15) ? 15 : e.cc);
                chk("retired_count4", e.id, int'(bus4.retired_count), (e.rc > 15) ? 15 : e.rc);
            end
        end
    end

    initial begin : stimulus
        drive(R | S);
        // reset with start held: stays IDLE, counters clear
        row(R | S, 0, 0, 1, 0, 0, 0);
        // start, 5 RUN cycles, halt, 3 DRAIN cycles, done
        row(S,     0, 0, 1, 0, 0, 0);
        row(0,     1, 1, 0, 0, 0, 0);
        row(0,     1, 1, 0, 0, 1, 0);
        row(0,     1, 1, 0, 0, 2, 0);
        row(0,     1, 1, 0, 0, 3, 0);
        row(H,     1, 1, 0, 0, 4, 0);
        row(0,     3, 0, 1, 0, 5, 0);
        row(0,     3, 0, 1, 0, 6, 0);
        row(0,     3, 0, 1, 0, 7, 0);
        row(H,     0, 0, 1, 1, 8, 0);
        row(0,     0, 0, 1, 0, 8, 0);
        row(C,     0, 0, 1, 0, 8, 0);
        // single step; requests during DRAIN dropped; one retirement
        row(P,     0, 0, 1, 0, 0, 0);
        row(0,     2, 1, 0, 0, 0, 0);
        row(S,     3, 0, 1, 0, 1, 0);
        row(W,     3, 0, 1, 0, 2, 0);
        row(P,     3, 0, 1, 0, 3, 1);
        row(0,     0, 0, 1, 1, 4, 1);
        // jumps in RUN, DRAIN and IDLE
        row(S,     0, 0, 1, 0, 4, 1);
        row(J,     1, 1, 1, 0, 4, 1);
        row(H,     1, 1, 0, 0, 5, 1);
        row(J,     3, 1, 1, 0, 6, 1);
        row(0,     3, 0, 1, 0, 7, 1);
        row(0,     3, 0, 1, 0, 8, 1);
        row(J,     0, 1, 1, 1, 9, 1);
        row(0,     0, 0, 1, 0, 9, 1);
        // 20 RUN cycles with wb_valid: 4-bit copy saturates at 15
        row(C,     0, 0, 1, 0, 9, 1);
        row(S,     0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 20; i++)
            row(W, 1, 1, 0, 0, i, i);
        row(C | W, 1, 1, 0, 0, 20, 20);
        row(H,     1, 1, 0, 0, 0, 0);
        // reset in second DRAIN cycle: IDLE, no done
        row(0,     3, 0, 1, 0, 1, 0);
        row(R,     3, 0, 1, 0, 2, 0);
        row(S | P, 0, 0, 1, 0, 0, 0);
        row(0,     1, 1, 0, 0, 0, 0);
        row(H,     1, 1, 0, 0, 1, 0);
        row(0,     3, 0, 1, 0, 2, 0);
        row(0,     3, 0, 1, 0, 3, 0);
        row(0,     3, 0, 1, 0, 4, 0);
        row(0,     0, 0, 1, 1, 5, 0);

        @(posedge clk); #1;
        drive(0);
        for (int k = 0; k < 5 && exp_q.size() > 0; k++)
            @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_queue: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
